dig_bcd_ctrl: RTL

- Sequential binary-to-BCD conversion controller for the 8-digit seven-segment display path.
- Accepts a write from the memory/IO decoder, latches the binary value and runs double-dabble one bit per clock.
- Holds the last completed 8-digit packed BCD result stable for the display scanner.
- Queues at most one request that arrives during a conversion, keeping the latest value.

---
 rtl/dig_bcd_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dig_bcd_ctrl.sv
// rtl/dig_bcd_ctrl.sv - sequential binary-to-BCD controller for the 8-digit display (optional macro: DIG_LEADING_ZERO_BLANK_EN)
module dig_bcd_ctrl #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  digwrite,
    input  logic                  digcs,
    input  logic [BIN_W-1:0]      binary,
    output logic [4*DIGITS-1:0]   decimal,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    // Accumulator carries one extra digit so the full binary range converts without loss.
    localparam int ACC_W = 4*DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(DIGITS) - 64'd1;

    // Double-dabble correction: any digit of 5 or more gets 3 added before the shift.
    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int k = 0; k < ACC_W/4; k++) begin
            if (a[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = a[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [BIN_W-1:0]       shift_q;
    logic [ACC_W-1:0]       acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_cap;
    logic                   pend_valid;
    logic [BIN_W-1:0]       pend_val;

    logic                   req;
    logic                   start;
    logic                   shift_en;
    logic                   capture;
    logic                   pend_store;
    logic                   pend_clear;
    logic [BIN_W-1:0]       start_val;
    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] shifted;

    assign req       = digcs & digwrite;
    assign start_val = (state == S_DONE && pend_valid) ? pend_val : binary;
    assign acc_adj   = add3(acc_q);
    assign shifted   = {acc_adj, shift_q} << 1;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; a queued request always wins over a new one in DONE.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        capture    = 1'b0;
        pend_store = 1'b0;
        pend_clear = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    start     = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy       = 1'b1;
                shift_en   = 1'b1;
                pend_store = req;
                if (cnt_q == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                capture = 1'b1;
                if (pend_valid) begin
                    start      = 1'b1;
                    pend_store = req;
                    pend_clear = ~req;
                    state_nxt  = S_SHIFT;
                end else if (req) begin
                    start     = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Conversion datapath, one-entry pending buffer and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_cap    <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            decimal    <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                decimal <= ovf_cap ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
                ovf     <= ovf_cap;
            end
            if (start) begin
                shift_q <= start_val;
                acc_q   <= '0;
                cnt_q   <= CNT_W'(BIN_W - 1);
                ovf_cap <= (64'(start_val) > MAX_DEC);
            end else if (shift_en) begin
                acc_q   <= shifted[ACC_W+BIN_W-1:BIN_W];
                shift_q <= shifted[BIN_W-1:0];
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if (pend_store) begin
                pend_valid <= 1'b1;
                pend_val   <= binary;
            end else if (pend_clear) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef DIG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_run;

    // Blank mask: a digit blanks when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            zero_run     = zero_run & (acc_q[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_run & ~ovf_cap;
        end
    end

    // Blank register moves together with decimal.
    always_ff @(posedge clock) begin
        if (reset) begin
            blank <= '0;
        end else if (capture) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule
